bcd_seg_scan: RTL and testbench
===============================

Name: bcd_seg_scan

Overview:
- Display stage directly downstream of the 8-bit binary-to-BCD converter.
- Latches the converter's three BCD digits (hundreds from bcd1, tens/ones from bcd0) on a load strobe.
- Time-multiplexes the latched digits onto one shared 7-segment bus with per-digit anode enables.
- Adds optional leading-zero blanking and an error indication for non-decimal nibbles.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal range 1..2^DIV_W-1.
- DIV_W, 16, prescaler counter width.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  capture strobe; when 1 at a rising edge, bcd1/bcd0 are latched.
- bcd1  input  4  hundreds digit from the converter.
- bcd0  input  8  [7:4] tens digit, [3:0] ones digit, from the converter.
- blank_lz  input  1  1 = suppress leading zeros.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  3  digit enables, active-low one-hot: [0] ones, [1] tens, [2] hundreds; registered.
- err  output  1  1 while any latched digit > 9; registered.

Behaviour:
- Reset (async assert, rst_n=0):
  - latched digits h/t/o = 0; prescaler cnt = 0; FSM state = S_ONES.
  - seg = 7'h7F (all off); an = 3'b111 (all off); err = 0.
- Capture:
  - If load=1 at edge k: h<=bcd1, t<=bcd0[7:4], o<=bcd0[3:0].
  - Otherwise the latched digits hold.
  - No handshake; load may be asserted every cycle.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (cnt == SCAN_DIV-1).
  - SCAN_DIV=1 gives tick every cycle.
- FSM:
  - States: S_ONES -> S_TENS -> S_HUND -> S_ONES.
  - Advances only on a cycle where tick=1; holds otherwise.
  - No other transitions; an illegal state encoding recovers to S_ONES on the next edge.
- Output register (seg, an, err), one-cycle latency:
  - Outputs at edge n+1 reflect the FSM state and the latched digits as they are after edge n.
  - Consequences: load at edge k shows on seg at edge k+1 if that digit is selected; first lit output is an=3'b110 at the first edge after reset release.
- Digit select by state:
  - S_ONES: an=3'b110, digit=o.
  - S_TENS: an=3'b101, digit=t.
  - S_HUND: an=3'b011, digit=h.
- Decode (active-low, g..a):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19.
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 10..15 = dash 7'h3F.
- Blanking, when blank_lz=1:
  - Hundreds slot: seg=7'h7F if h==0.
  - Tens slot: seg=7'h7F if h==0 and t==0.
  - Ones slot: never blanked.
  - an still pulses while blanked, so scan timing is unchanged.
  - An invalid digit (>9) is never treated as zero and is never blanked.
- err = (h>9)|(t>9)|(o>9), evaluated on the latched digits and registered with the same latency as seg.
- Simultaneous load and tick: both take effect at the same edge; the newly selected digit shows the new value one edge later.
- blank_lz is sampled combinationally into the output register every cycle (no latch).
- Reset mid-scan: all state and outputs return to reset values immediately (asynchronous); the scan restarts at S_ONES.

Decomposition:
- Shared package/include holds:
  - state encodings S_ONES=2'd0, S_TENS=2'd1, S_HUND=2'd2;
  - segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, and the ten digit patterns.
- One combinational sub-module, bcd_to_seg7 (4-bit digit in, 7-bit active-low pattern out), used once on the muxed digit.
- Prescaler, FSM, capture registers and output register stay in bcd_seg_scan.

Test Plan:
- Reset value: rst_n=0 mid-count -> seg=7'h7F, an=3'b111, err=0 immediately (before any clock edge); after release, first edge gives an=3'b110, seg=7'h40.
- Full scan: SCAN_DIV=4, load bcd1=4'h2, bcd0=8'h55 (value 255) -> repeating 4-cycle slots:
  - an=110 seg=7'h12;
  - an=101 seg=7'h12;
  - an=011 seg=7'h24;
  - wrap back to 110 after 12 cycles.
- Blanking: blank_lz=1, bcd1=0, bcd0=8'h07 -> ones slot seg=7'h78; tens and hundreds slots seg=7'h7F with an still cycling; with blank_lz=0 those slots show 7'h40.
- Invalid digit: bcd1=0, bcd0=8'hA3, blank_lz=1 -> tens slot seg=7'h3F (not blanked), ones slot 7'h30, hundreds slot 7'h7F, err=1; load 8'h23 -> err=0 one edge after the load edge.
- Load/tick collision: SCAN_DIV=1, load=1 on the same edge the FSM enters S_TENS with new bcd0=8'h90 -> the following edge shows an=101, seg=7'h10.
- Latency: load bcd0=8'h08 while in S_ONES with no tick pending -> seg changes from its old pattern to 7'h00 exactly one edge after the load edge.

Source files
------------

// File: rtl/bcd_seg_scan_pkg.sv
// rtl/bcd_seg_scan_pkg.sv - shared state encodings and 7-segment patterns
package bcd_seg_scan_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [2:0] AN_OFF  = 3'b111;
  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - converter-to-display bus with segment/anode outputs
interface bcd_seg_scan_if;
  logic       load;
  logic [3:0] bcd1;
  logic [7:0] bcd0;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;

  modport master (
    output load, bcd1, bcd0, blank_lz,
    input  seg, an, err
  );

  modport slave (
    input  load, bcd1, bcd0, blank_lz,
    output seg, an, err
  );
endinterface

// File: rtl/bcd_seg_scan_bcd_to_seg7.sv
// rtl/bcd_seg_scan_bcd_to_seg7.sv - BCD digit to active-low 7-segment pattern
module bcd_to_seg7
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - latches three BCD digits and scans them onto one 7-segment bus
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_h, r_t, r_o;
  logic [DIV_W-1:0] r_cnt;
  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic             w_tick;
  logic [3:0]       w_digit;
  logic [2:0]       w_an;
  logic             w_blank;
  logic [6:0]       w_dec;
  logic [6:0]       w_seg_nxt;
  logic             w_err;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= 4'd0;
      r_t <= 4'd0;
      r_o <= 4'd0;
    end else if (bus.load) begin
      r_h <= bus.bcd1;
      r_t <= bus.bcd0[7:4];
      r_o <= bus.bcd0[3:0];
    end
  end

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ONES;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_ONES;
    case (r_state)
      S_ONES:  w_state_nxt = w_tick ? S_TENS : S_ONES;
      S_TENS:  w_state_nxt = w_tick ? S_HUND : S_TENS;
      S_HUND:  w_state_nxt = w_tick ? S_ONES : S_HUND;
      default: w_state_nxt = S_ONES;
    endcase
  end

  // Only a true zero suppresses; a dash (>9) in a leading slot stays visible.
  always_comb begin
    w_an    = AN_OFF;
    w_digit = r_o;
    w_blank = 1'b1;
    case (r_state)
      S_ONES: begin
        w_an    = AN_ONES;
        w_digit = r_o;
        w_blank = 1'b0;
      end
      S_TENS: begin
        w_an    = AN_TENS;
        w_digit = r_t;
        w_blank = bus.blank_lz && (r_h == 4'd0) && (r_t == 4'd0);
      end
      S_HUND: begin
        w_an    = AN_HUND;
        w_digit = r_h;
        w_blank = bus.blank_lz && (r_h == 4'd0);
      end
      default: begin
        w_an    = AN_OFF;
        w_digit = r_o;
        w_blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  assign w_seg_nxt = w_blank ? SEG_BLANK : w_dec;
  assign w_err     = (r_h > 4'd9) | (r_t > 4'd9) | (r_o > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
      r_err <= 1'b0;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an;
      r_err <= w_err;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.err = r_err;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - directed self-checking bench for bcd_seg_scan
module tb_bcd_seg_scan;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  bcd_seg_scan_if if4 ();
  bcd_seg_scan_if if1 ();

  bcd_seg_scan #(.SCAN_DIV(4), .DIV_W(16)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  bcd_seg_scan #(.SCAN_DIV(1), .DIV_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset, then latch (b1,b0) on edge 1; returns just after edge 1.
  task automatic reset_and_load(input logic [3:0] b1, input logic [7:0] b0, input logic blz);
    @(negedge clk);
    rst_n        = 1'b0;
    if4.load     = 1'b1;
    if4.bcd1     = b1;
    if4.bcd0     = b0;
    if4.blank_lz = blz;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if4.load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    if4.load     = 1'b0; if4.bcd1 = 4'd0; if4.bcd0 = 8'h00; if4.blank_lz = 1'b0;
    if1.load     = 1'b0; if1.bcd1 = 4'd0; if1.bcd0 = 8'h00; if1.blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    if4.load = 1'b1;
    if4.bcd0 = 8'hA5;
    @(negedge clk);
    if4.load = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (if4.err !== 1'b1) $display("FAIL reset_pre_err: got %b want 1", if4.err);
    else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if4.seg !== 7'h7F || if4.an !== 3'b111 || if4.err !== 1'b0)
      $display("FAIL reset_async4: seg=%h an=%b err=%b want 7f 111 0", if4.seg, if4.an, if4.err);
    else n_pass++;
    n_checks++;
    if (if1.seg !== 7'h7F || if1.an !== 3'b111 || if1.err !== 1'b0)
      $display("FAIL reset_async1: seg=%h an=%b err=%b want 7f 111 0", if1.seg, if1.an, if1.err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if4.an !== 3'b110 || if4.seg !== 7'h40 || if4.err !== 1'b0)
      $display("FAIL reset_first_edge: an=%b seg=%h err=%b want 110 40 0", if4.an, if4.seg, if4.err);
    else n_pass++;
  endtask

  task automatic test_full_scan;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    reset_and_load(4'h2, 8'h55, 1'b0);
    for (int e = 2; e <= 13; e++) begin
      @(negedge clk);
      case (((e - 1) / 4) % 3)
        0:       begin exp_an = 3'b110; exp_seg = 7'h12; end
        1:       begin exp_an = 3'b101; exp_seg = 7'h12; end
        default: begin exp_an = 3'b011; exp_seg = 7'h24; end
      endcase
      n_checks++;
      if (if4.an !== exp_an || if4.seg !== exp_seg || if4.err !== 1'b0)
        $display("FAIL full_scan e=%0d: an=%b seg=%h err=%b want %b %h 0",
                 e, if4.an, if4.seg, if4.err, exp_an, exp_seg);
      else n_pass++;
    end
  endtask

  task automatic test_blanking;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    reset_and_load(4'h0, 8'h07, 1'b1);
    for (int e = 2; e <= 24; e++) begin
      @(negedge clk);
      case (((e - 1) / 4) % 3)
        0:       begin exp_an = 3'b110; exp_seg = 7'h78; end
        1:       begin exp_an = 3'b101; exp_seg = (e <= 12) ? 7'h7F : 7'h40; end
        default: begin exp_an = 3'b011; exp_seg = (e <= 12) ? 7'h7F : 7'h40; end
      endcase
      n_checks++;
      if (if4.an !== exp_an || if4.seg !== exp_seg)
        $display("FAIL blanking e=%0d: an=%b seg=%h want %b %h", e, if4.an, if4.seg, exp_an, exp_seg);
      else n_pass++;
      if (e == 12) if4.blank_lz = 1'b0;
    end
  endtask

  task automatic test_invalid;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    reset_and_load(4'h0, 8'hA3, 1'b1);
    for (int e = 2; e <= 13; e++) begin
      @(negedge clk);
      case (((e - 1) / 4) % 3)
        0:       begin exp_an = 3'b110; exp_seg = 7'h30; end
        1:       begin exp_an = 3'b101; exp_seg = 7'h3F; end
        default: begin exp_an = 3'b011; exp_seg = 7'h7F; end
      endcase
      n_checks++;
      if (if4.an !== exp_an || if4.seg !== exp_seg || if4.err !== 1'b1)
        $display("FAIL invalid e=%0d: an=%b seg=%h err=%b want %b %h 1",
                 e, if4.an, if4.seg, if4.err, exp_an, exp_seg);
      else n_pass++;
    end
    if4.load = 1'b1;
    if4.bcd0 = 8'h23;
    @(negedge clk);
    if4.load = 1'b0;
    n_checks++;
    if (if4.err !== 1'b1) $display("FAIL err_load_edge: got %b want 1", if4.err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if4.err !== 1'b0) $display("FAIL err_clear: got %b want 0", if4.err);
    else n_pass++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    rst_n        = 1'b0;
    if1.load     = 1'b1;
    if1.bcd1     = 4'h0;
    if1.bcd0     = 8'h90;
    if1.blank_lz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if1.load = 1'b0;
    n_checks++;
    if (if1.an !== 3'b110 || if1.seg !== 7'h40)
      $display("FAIL collision_e1: an=%b seg=%h want 110 40", if1.an, if1.seg);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if1.an !== 3'b101 || if1.seg !== 7'h10)
      $display("FAIL collision_e2: an=%b seg=%h want 101 10", if1.an, if1.seg);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if1.an !== 3'b011 || if1.seg !== 7'h40)
      $display("FAIL collision_e3: an=%b seg=%h want 011 40", if1.an, if1.seg);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if1.an !== 3'b110 || if1.seg !== 7'h40)
      $display("FAIL collision_e4: an=%b seg=%h want 110 40", if1.an, if1.seg);
    else n_pass++;
  endtask

  task automatic test_latency;
    reset_and_load(4'h0, 8'h01, 1'b0);
    if4.load = 1'b1;
    if4.bcd0 = 8'h08;
    @(negedge clk);
    if4.load = 1'b0;
    n_checks++;
    if (if4.an !== 3'b110 || if4.seg !== 7'h79)
      $display("FAIL latency_load_edge: an=%b seg=%h want 110 79", if4.an, if4.seg);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if4.an !== 3'b110 || if4.seg !== 7'h00)
      $display("FAIL latency_next_edge: an=%b seg=%h want 110 00", if4.an, if4.seg);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_full_scan();
    test_blanking();
    test_invalid();
    test_collision();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
